// File: rtl/demux_stream_1x2_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer: default widths,
// output indices and the per-buffer occupancy encoding.
package demux_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  localparam int OUT0 = 0;
  localparam int OUT1 = 1;

  // Occupancy of a 2-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/demux_stream_1x2_if.sv
// Stream bundle for the demultiplexer: one input stream with a route bit,
// two output streams and the per-output accepted-word counters.
interface demux_stream_1x2_if
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Demultiplexer side.
  modport slave (
    input  in_data, in_sel, in_valid,
    output in_ready,
    output out0_data, out0_valid,
    input  out0_ready,
    output out1_data, out1_valid,
    input  out1_ready,
    output cnt0, cnt1
  );

  // Producer/consumer side.
  modport master (
    output in_data, in_sel, in_valid,
    input  in_ready,
    input  out0_data, out0_valid,
    output out0_ready,
    input  out1_data, out1_valid,
    output out1_ready,
    input  cnt0, cnt1
  );

endinterface

// File: rtl/demux_stream_1x2_fifo2.sv
// Two-entry FIFO kept as head/tail registers: the head register always holds
// the oldest word, so head_data needs no read multiplexer and stays stable
// until it is popped.
module fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head_data
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             push_en;
  logic             pop_en;

  // A push into a full buffer or a pop from an empty one is ignored.
  assign push_en   = push && (occ_q != FULL);
  assign pop_en    = pop && (occ_q != EMPTY);
  assign valid     = (occ_q != EMPTY);
  assign full      = (occ_q == FULL);
  assign head_data = head_q;

  // Next occupancy and entry contents for push, pop or both.
  // NOTE: every *_d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_en, pop_en})
      2'b10: begin
        if (occ_q == EMPTY) begin
          head_d = push_data;
          occ_d  = ONE;
        end else begin
          tail_d = push_data;
          occ_d  = FULL;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = (occ_q == FULL) ? ONE : EMPTY;
      end
      // Push and pop together only happens at occupancy ONE (push_en
      // excludes FULL, pop_en excludes EMPTY): the new word becomes head.
      2'b11: head_d = push_data;
      default: ;
    endcase
  end

  // Occupancy register; reset discards any buffered words.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= EMPTY;
    else        occ_q <= occ_d;
  end

  // Entry storage.
  // NOTE: data entries are not reset; they are qualified by occupancy.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: rtl/demux_stream_1x2.sv
// Pipelined 1-to-2 stream demultiplexer. Each accepted word is steered by
// in_sel into one of two 2-entry output buffers; per-output counters track
// accepted words. in_ready depends only on in_sel and registered occupancy.
module demux_stream_1x2
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_stream_1x2_if.slave  bus
);

  logic [1:0]       full;
  logic [1:0]       push;
  logic             in_ready;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Head-of-line: a word aimed at a full buffer stalls the input.
  assign in_ready     = bus.in_sel ? !full[OUT1] : !full[OUT0];
  assign bus.in_ready = in_ready;

  assign push[OUT0] = bus.in_valid && in_ready && !bus.in_sel;
  assign push[OUT1] = bus.in_valid && in_ready &&  bus.in_sel;

  fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[OUT0]),
    .push_data (bus.in_data),
    .pop       (bus.out0_ready),
    .valid     (bus.out0_valid),
    .full      (full[OUT0]),
    .head_data (bus.out0_data)
  );

  fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push[OUT1]),
    .push_data (bus.in_data),
    .pop       (bus.out1_ready),
    .valid     (bus.out1_valid),
    .full      (full[OUT1]),
    .head_data (bus.out1_data)
  );

  // Accepted-word counters, wrapping modulo 2^CNT_W.
  always_comb begin
    cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, push[OUT0]};
    cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, push[OUT1]};
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;

endmodule

// File: doc/demux_stream_1x2.md
# demux_stream_1x2

Pipelined 1-to-2 stream demultiplexer: the dual of the 2:1 select used in the shifter datapath. Each accepted input word is steered by a per-word select bit to one of two output streams. Each output has a 2-entry buffer so traffic keeps flowing at full rate under valid/ready backpressure. It sits after the pipelined barrel shifter and splits shifter results between two downstream consumers.

## Interface
Parameters:
- WIDTH, 32, data word width
- CNT_W, 16, width of per-output accepted-word counters

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  WIDTH  input word
- in_sel  in  1  route: 0 → out0, 1 → out1; qualified by in_valid
- in_valid  in  1  input word present
- in_ready  out  1  block can accept the input word this cycle
- out0_data / out1_data  out  WIDTH  head word of the corresponding buffer
- out0_valid / out1_valid  out  1  buffer non-empty
- out0_ready / out1_ready  in  1  consumer accepts the head word
- cnt0 / cnt1  out  CNT_W  number of words accepted for each output, modulo 2^CNT_W

## Operation
- Input transfer occurs when in_valid && in_ready at a rising edge.
- in_ready = !full[in_sel]:
  - Combinational from in_sel and the buffer state only; it does not depend on in_valid.
  - No combinational path from out*_ready to in_ready.
- Output k transfer occurs when outk_valid && outk_ready.
- Per output buffer, a 2-entry FIFO with occupancy 0/1/2:
  - Push only: occupancy +1.
  - Pop only: occupancy −1.
  - Push and pop in the same cycle: occupancy unchanged, order preserved.
  - Push when full is impossible, because in_ready gates it.
  - outk_valid = occupancy != 0.
  - outk_data = oldest entry. It is held stable while outk_valid && !outk_ready.
- Word order is preserved within each output. There is no ordering relation between the two outputs.
- Head-of-line blocking: if the input word targets a full buffer, the input stalls even when the other buffer is free. This is intended.
- cntk increments by 1 on every input transfer with in_sel == k. It wraps from 2^CNT_W−1 to 0.
- outk_data is a don't-care while outk_valid == 0. The implementation drives stale entry contents; the bench must not check it.

## Timing
- Reset (async assert, any cycle, including mid-transfer):
  - All buffers empty, out0_valid = out1_valid = 0.
  - cnt0 = cnt1 = 0.
  - in_ready = 1 while reset is held low.
  - Buffered words are discarded.
- Reset deassertion is synchronised by the integrator. First transfer is possible at the first rising edge with rst_n high.
- Latency: a word accepted at edge N is visible on outk_data with outk_valid = 1 after edge N. It can be consumed at edge N+1.
- Throughput: one word per cycle to either output while the consumer keeps outk_ready = 1.
- With outk_ready held low, output k absorbs exactly 2 words. in_ready then drops combinationally whenever in_sel == k.
- Full buffer with a simultaneous pop: in_ready is still 0 that cycle (ready is computed from the registered occupancy). A new push is accepted in the next cycle. This is one bubble by design.

## Structure
- Shared package (demux_pkg) holds:
  - WIDTH and CNT_W defaults.
  - Output-index localparams OUT0 = 0, OUT1 = 1.
  - The occupancy encoding: 2-bit values EMPTY = 0, ONE = 1, FULL = 2.
- Sub-module fifo2: a parameterised 2-entry FIFO with push/pop, valid, full and head data. It is instantiated twice.
- Top level contains only:
  - the in_ready selection;
  - push decode (in_valid && in_ready && in_sel == k);
  - the two counters.

## Test plan
- Reset mid-stream:
  - Stimulus: push 0xA5A5A5A5 to out1 with out1_ready = 0, then pull rst_n low between edges.
  - Required: out1_valid = 0 and cnt1 = 0 immediately, before the next edge. in_ready = 1.
- Alternating route at full rate:
  - Stimulus: words 0x1..0x8 with in_sel = 0,1,0,1…, both readies = 1.
  - Required: out0 sees 1,3,5,7 and out1 sees 2,4,6,8, each 1 cycle after acceptance. in_ready stays 1. cnt0 = cnt1 = 4.
- Backpressure fill:
  - Stimulus: out0_ready = 0, push 0x10, 0x11, 0x12 with in_sel = 0.
  - Required: first two accepted. in_ready = 0 on the third. out0_data holds 0x10.
  - Then out0_ready = 1: outputs 0x10, 0x11, 0x12 in order. 0x12 is accepted the cycle after the first pop.
- Head-of-line:
  - Stimulus: out0 full; input presents in_sel = 0, then switches to in_sel = 1 while still valid.
  - Required: in_ready goes 0 → 1 combinationally with in_sel. The word goes to out1. out0 contents are unchanged.
- Simultaneous push/pop at occupancy 1 on out1:
  - Required: occupancy stays 1 and order is preserved over 16 back-to-back words 0x100..0x10F.
- Counter wrap:
  - Stimulus: CNT_W = 4, send 17 words to out0.
  - Required: cnt0 = 1.
